centroid_tracker: RTL and testbench
===================================

Name: centroid_tracker

Overview:
- Sits directly downstream of the per-channel binarization LUT stage in the video path and consumes its thresholded pixel stream.
- Accumulates X/Y coordinate sums and the object pixel count over each frame.
- At frame end, runs a sequential restoring divider and publishes the object centroid.
- Video timing and pixels pass through with a fixed 1-cycle delay, optionally with a crosshair drawn at the last centroid.

Parameters:
- CNT_W, 11, width of x/y position counters and of centroid outputs (max 2047 px per axis).
- PIX_W, 21, width of object pixel counter (up to 2^21-1 pixels).
- SUM_W, 32, width of coordinate accumulators and divider length in cycles.

Ports:
- clk  in  1  pixel clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- de_in  in  1  data enable, high during active pixels.
- v_sync_in  in  1  vertical sync, active-high.
- h_sync_in  in  1  horizontal sync, active-high.
- pixel_in  in  24  binarized pixel; [7:0]=R, [15:8]=G, [23:16]=B.
- de_out  out  1  de_in delayed 1 cycle.
- v_sync_out  out  1  v_sync_in delayed 1 cycle.
- h_sync_out  out  1  h_sync_in delayed 1 cycle.
- pixel_out  out  24  pixel_in delayed 1 cycle (see Optional Feature).
- centroid_x  out  CNT_W  floor(sum_x/count) of last completed frame.
- centroid_y  out  CNT_W  floor(sum_y/count) of last completed frame.
- obj_count  out  PIX_W  object pixel count of last completed frame.
- centroid_valid  out  1  1-cycle pulse when the centroid outputs update.
- obj_empty  out  1  high when the last completed frame had count==0.

Behaviour:
- Reset: all outputs, counters, accumulators and divider state are 0; the FSM goes to ACC. Reset mid-division aborts it and no valid pulse is issued.
- Object pixel: obj = de_in & pixel_in[7] & pixel_in[15] & pixel_in[23].
- x counter:
  - increments on each de_in=1 cycle;
  - clears to 0 on the first cycle with de_in=0 after de_in=1 (falling edge of de).
- y counter:
  - increments on the de falling edge;
  - clears to 0 on the v_sync_in rising edge.
- Accumulation, on each obj cycle: sum_x += x, sum_y += y, count += 1, all using the current x/y before increment. Accumulators saturate at their all-ones value; no wrap.
- Frame end is the v_sync_in rising edge (registered v_sync compared to the current sample). On that cycle:
  - sum_x, sum_y and count are latched into divider operands;
  - the accumulators and y clear;
  - the FSM moves ACC -> DIV.
- FSM states:
  - ACC: idle divider; accumulation always runs, independent of FSM state.
  - DIV: two parallel restoring dividers (sum_x/count, sum_y/count) at one quotient bit per cycle for exactly SUM_W cycles, then -> DONE.
  - If count==0 at latch, go ACC -> DONE directly, skipping DIV.
  - DONE: one cycle. Loads centroid_x/centroid_y from the low CNT_W quotient bits (0 if empty), loads obj_count, sets obj_empty, pulses centroid_valid, then -> ACC.
- Latency: centroid_valid is high in cycle N+SUM_W+1, where N is the frame-end cycle; for empty frames it is N+1.
- A frame end arriving during DIV restarts the division with the new operands; the old result is discarded.
- Outputs hold their values between valid pulses.
- Pass-through: de, h_sync, v_sync and pixel are each registered once; latency is exactly 1 cycle and unaffected by FSM state.

Optional Feature:
- Macro: CENTROID_CROSSHAIR_EN.
- Defined: pixel_out = 24'h0000FF (pure R) on delayed pixels with de high where x==centroid_x or y==centroid_y. Applies only after at least one non-empty centroid; otherwise pixel_out is the delayed pixel_in.
- Undefined: pixel_out is always the delayed pixel_in; no comparator logic is built.

Test Plan:
- Single white pixel at (5,3) in an 8x6 frame, rest 0x000000 -> after the next v_sync rise: centroid_x=5, centroid_y=3, obj_count=1, obj_empty=0, one centroid_valid pulse at N+33.
- 2x2 block at x=2..3, y=4..5 -> sum_x=10, sum_y=18, count=4 -> centroid_x=2, centroid_y=4 (floor).
- All-black frame -> obj_empty=1, centroid_x=centroid_y=0, obj_count=0, valid pulse at N+1.
- Full white 8x6 frame -> count=48, sum_x=168, sum_y=120 -> centroid_x=3, centroid_y=2.
- Assert rst 10 cycles into DIV -> no centroid_valid pulse and all outputs 0. Next frame computes correctly.
- Random pixels/syncs -> de_out, h_sync_out, v_sync_out and pixel_out equal the inputs delayed exactly 1 cycle (CENTROID_CROSSHAIR_EN undefined). With it defined after the (5,3) frame, pixels on column 5 and row 3 read 24'h0000FF.

Source files
------------

// File: rtl/centroid_tracker.sv
// centroid_tracker: accumulates object-pixel coordinates per frame and
// publishes floor(sum/count) centroids via two serial restoring dividers.
// Ports: clk/rst (sync, active-high); de/v_sync/h_sync/pixel in -> out with
// 1-cycle delay; centroid_x/centroid_y/obj_count/obj_empty hold the last
// completed frame's result, centroid_valid pulses for one cycle on update.
// Optional: define CENTROID_CROSSHAIR_EN to paint a red crosshair at the last
// non-empty centroid on pixel_out.
module centroid_tracker #(
  parameter int CNT_W = 11,
  parameter int PIX_W = 21,
  parameter int SUM_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             de_in,
  input  logic             v_sync_in,
  input  logic             h_sync_in,
  input  logic [23:0]      pixel_in,
  output logic             de_out,
  output logic             v_sync_out,
  output logic             h_sync_out,
  output logic [23:0]      pixel_out,
  output logic [CNT_W-1:0] centroid_x,
  output logic [CNT_W-1:0] centroid_y,
  output logic [PIX_W-1:0] obj_count,
  output logic             centroid_valid,
  output logic             obj_empty
);

  localparam int DC_W = $clog2(SUM_W + 1);

  typedef enum logic [1:0] {ACC, DIV, DONE} state_t;
  state_t state;

  logic [CNT_W-1:0] x_cnt, y_cnt;
  logic [SUM_W-1:0] sum_x, sum_y;
  logic [PIX_W-1:0] count;

  logic [SUM_W-1:0] quo_x, quo_y;
  logic [PIX_W-1:0] rem_x, rem_y;
  logic [PIX_W-1:0] divisor;
  logic [DC_W-1:0]  div_cnt;

  logic obj, de_fall, frame_end, div_last;
  assign obj       = de_in & pixel_in[7] & pixel_in[15] & pixel_in[23];
  assign de_fall   = de_out & ~de_in;        // de_out is de_in registered
  assign frame_end = v_sync_in & ~v_sync_out;
  assign div_last  = (state == DIV) && !frame_end && (div_cnt == DC_W'(SUM_W - 1));

  // Saturating accumulators: the extra top bit is the overflow flag.
  logic [SUM_W:0]   sx_add, sy_add;
  logic [SUM_W-1:0] sx_nxt, sy_nxt;
  assign sx_add = {1'b0, sum_x} + {{(SUM_W + 1 - CNT_W){1'b0}}, x_cnt};
  assign sy_add = {1'b0, sum_y} + {{(SUM_W + 1 - CNT_W){1'b0}}, y_cnt};
  assign sx_nxt = sx_add[SUM_W] ? '1 : sx_add[SUM_W-1:0];
  assign sy_nxt = sy_add[SUM_W] ? '1 : sy_add[SUM_W-1:0];

  // One restoring step per cycle. The remainder stays below the divisor, so
  // the low PIX_W bits of the difference are exact whenever it is kept.
  logic [PIX_W:0]   rx_sh, ry_sh;
  logic [PIX_W-1:0] rx_sub, ry_sub, rx_nxt, ry_nxt;
  logic             qx_bit, qy_bit;
  logic [SUM_W-1:0] qx_nxt, qy_nxt;
  assign rx_sh  = {rem_x, quo_x[SUM_W-1]};
  assign ry_sh  = {rem_y, quo_y[SUM_W-1]};
  assign qx_bit = (rx_sh >= {1'b0, divisor});
  assign qy_bit = (ry_sh >= {1'b0, divisor});
  assign rx_sub = rx_sh[PIX_W-1:0] - divisor;
  assign ry_sub = ry_sh[PIX_W-1:0] - divisor;
  assign rx_nxt = qx_bit ? rx_sub : rx_sh[PIX_W-1:0];
  assign ry_nxt = qy_bit ? ry_sub : ry_sh[PIX_W-1:0];
  assign qx_nxt = {quo_x[SUM_W-2:0], qx_bit};
  assign qy_nxt = {quo_y[SUM_W-2:0], qy_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      de_out         <= 1'b0;
      v_sync_out     <= 1'b0;
      h_sync_out     <= 1'b0;
      x_cnt          <= '0;
      y_cnt          <= '0;
      sum_x          <= '0;
      sum_y          <= '0;
      count          <= '0;
      quo_x          <= '0;
      quo_y          <= '0;
      rem_x          <= '0;
      rem_y          <= '0;
      divisor        <= '0;
      div_cnt        <= '0;
      centroid_x     <= '0;
      centroid_y     <= '0;
      obj_count      <= '0;
      obj_empty      <= 1'b0;
      centroid_valid <= 1'b0;
      state          <= ACC;
    end else begin
      de_out     <= de_in;
      v_sync_out <= v_sync_in;
      h_sync_out <= h_sync_in;

      if (de_in)        x_cnt <= x_cnt + CNT_W'(1);
      else if (de_fall) x_cnt <= '0;

      if (frame_end)    y_cnt <= '0;
      else if (de_fall) y_cnt <= y_cnt + CNT_W'(1);

      // Frame end wins over a coincident object pixel (it belongs to no frame).
      if (frame_end) begin
        sum_x <= '0;
        sum_y <= '0;
        count <= '0;
      end else if (obj) begin
        sum_x <= sx_nxt;
        sum_y <= sy_nxt;
        if (!(&count)) count <= count + PIX_W'(1);
      end

      centroid_valid <= 1'b0;

      // Results are registered on the transition into DONE so the pulse and
      // the new values are visible together during the DONE cycle.
      if (frame_end) begin
        quo_x   <= sum_x;
        quo_y   <= sum_y;
        rem_x   <= '0;
        rem_y   <= '0;
        divisor <= count;
        div_cnt <= '0;
        if (count == '0) begin
          centroid_x     <= '0;
          centroid_y     <= '0;
          obj_count      <= '0;
          obj_empty      <= 1'b1;
          centroid_valid <= 1'b1;
          state          <= DONE;
        end else begin
          state <= DIV;
        end
      end else begin
        case (state)
          DIV: begin
            quo_x   <= qx_nxt;
            quo_y   <= qy_nxt;
            rem_x   <= rx_nxt;
            rem_y   <= ry_nxt;
            div_cnt <= div_cnt + 1'b1;
            if (div_last) begin
              centroid_x     <= qx_nxt[CNT_W-1:0];
              centroid_y     <= qy_nxt[CNT_W-1:0];
              obj_count      <= divisor;
              obj_empty      <= 1'b0;
              centroid_valid <= 1'b1;
              state          <= DONE;
            end
          end
          DONE:    state <= ACC;
          default: state <= ACC;
        endcase
      end
    end
  end

`ifdef CENTROID_CROSSHAIR_EN
  logic have_cent;
  always_ff @(posedge clk) begin
    if (rst) begin
      have_cent <= 1'b0;
      pixel_out <= '0;
    end else begin
      if (div_last) have_cent <= 1'b1;
      // x_cnt/y_cnt are the coordinates of the pixel being registered now.
      if (have_cent && de_in && (x_cnt == centroid_x || y_cnt == centroid_y))
        pixel_out <= 24'h0000FF;
      else
        pixel_out <= pixel_in;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) pixel_out <= '0;
    else     pixel_out <= pixel_in;
  end
`endif

endmodule

// File: tb/tb_centroid_tracker.sv
module tb_centroid_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        de_in, v_sync_in, h_sync_in;
  logic [23:0] pixel_in;
  logic        de_out, v_sync_out, h_sync_out;
  logic [23:0] pixel_out;
  logic [10:0] centroid_x, centroid_y;
  logic [20:0] obj_count;
  logic        centroid_valid, obj_empty;

  int total = 0;
  int bad   = 0;

  centroid_tracker dut (
    .clk(clk), .rst(rst),
    .de_in(de_in), .v_sync_in(v_sync_in), .h_sync_in(h_sync_in), .pixel_in(pixel_in),
    .de_out(de_out), .v_sync_out(v_sync_out), .h_sync_out(h_sync_out), .pixel_out(pixel_out),
    .centroid_x(centroid_x), .centroid_y(centroid_y), .obj_count(obj_count),
    .centroid_valid(centroid_valid), .obj_empty(obj_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          x0, x1, y0, y1;   // inclusive rectangle of foreground pixels
    logic [23:0] fg, bg;
    int          ecx, ecy, ecnt, eempty, lat;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Apply inputs for one cycle; returns 1 time unit after the sampling edge.
  task automatic drive(input logic de, input logic vs, input logic hs, input logic [23:0] px);
    de_in = de; v_sync_in = vs; h_sync_in = hs; pixel_in = px;
    @(posedge clk); #1;
  endtask

  // 8x6 active area, two blanking cycles per line (one with h_sync).
  task automatic send_frame(input vec_t v);
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++)
        drive(1'b1, 1'b0, 1'b0,
              (x >= v.x0 && x <= v.x1 && y >= v.y0 && y <= v.y1) ? v.fg : v.bg);
      drive(1'b0, 1'b0, 1'b1, 24'h0);
      drive(1'b0, 1'b0, 1'b0, 24'h0);
    end
  endtask

  // Issue the frame end, then watch 45 cycles for exactly one pulse at lat.
  task automatic frame_end_check(input string nm, input int lat, input int cx, input int cy,
                                 input int cnt, input int empty);
    int npulse, pos;
    npulse = 0; pos = -1;
    drive(1'b0, 1'b1, 1'b0, 24'h0);
    for (int c = 1; c <= 45; c++) begin
      if (centroid_valid) begin npulse++; pos = c; end
      drive(1'b0, 1'b0, 1'b0, 24'h0);
    end
    chk({nm, "_npulse"}, npulse, 1);
    chk({nm, "_lat"}, pos, lat);
    chk({nm, "_cx"}, centroid_x, cx);
    chk({nm, "_cy"}, centroid_y, cy);
    chk({nm, "_cnt"}, obj_count, cnt);
    chk({nm, "_empty"}, obj_empty, empty);
  endtask

  initial begin
    vt[0] = '{5, 5, 3, 3, 24'hFFFFFF, 24'h000000, 5, 3, 1,  0, 33};
    vt[1] = '{2, 3, 4, 5, 24'hFFFFFF, 24'h000000, 2, 4, 4,  0, 33};
    vt[2] = '{1, 0, 1, 0, 24'hFFFFFF, 24'h000000, 0, 0, 0,  1, 1};
    vt[3] = '{0, 7, 0, 5, 24'hFFFFFF, 24'h000000, 3, 2, 48, 0, 33};
    vt[4] = '{7, 7, 0, 5, 24'h808080, 24'h80807F, 7, 2, 6,  0, 33};

    rst = 1'b1;
    de_in = 1'b0; v_sync_in = 1'b0; h_sync_in = 1'b0; pixel_in = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_cx", centroid_x, 0);
    chk("rst_cy", centroid_y, 0);
    chk("rst_cnt", obj_count, 0);
    chk("rst_empty", obj_empty, 0);
    chk("rst_valid", centroid_valid, 0);
    chk("rst_de_out", de_out, 0);
    chk("rst_pix_out", pixel_out, 0);

    for (int i = 0; i < 5; i++) begin
      send_frame(vt[i]);
      frame_end_check($sformatf("vec%0d", i), vt[i].lat, vt[i].ecx, vt[i].ecy,
                      vt[i].ecnt, vt[i].eempty);
`ifdef CENTROID_CROSSHAIR_EN
      if (i == 0) begin
        for (int y = 0; y < 6; y++) begin
          for (int x = 0; x < 8; x++) begin
            drive(1'b1, 1'b0, 1'b0, 24'h0);
            chk($sformatf("xhair_%0d_%0d", x, y), pixel_out,
                (x == 5 || y == 3) ? 32'h0000FF : 32'h0);
          end
          drive(1'b0, 1'b0, 1'b1, 24'h0);
          drive(1'b0, 1'b0, 1'b0, 24'h0);
        end
        frame_end_check("xhair_fe", 1, 0, 0, 0, 1);
      end
`endif
    end

    // Frame end during DIV restarts with the new operands; old result dropped.
    send_frame(vt[0]);
    drive(1'b0, 1'b1, 1'b0, 24'h0);
    drive(1'b1, 1'b0, 1'b0, 24'h000000);
    drive(1'b1, 1'b0, 1'b0, 24'hFFFFFF);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    frame_end_check("restart", 33, 1, 0, 1, 0);

    // Reset 10 cycles into DIV: no pulse, outputs cleared, next frame correct.
    begin
      int npulse;
      npulse = 0;
      send_frame(vt[3]);
      drive(1'b0, 1'b1, 1'b0, 24'h0);
      repeat (10) drive(1'b0, 1'b0, 1'b0, 24'h0);
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 24'h0);
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (centroid_valid) npulse++;
        drive(1'b0, 1'b0, 1'b0, 24'h0);
      end
      chk("midrst_npulse", npulse, 0);
      chk("midrst_cx", centroid_x, 0);
      chk("midrst_cy", centroid_y, 0);
      chk("midrst_cnt", obj_count, 0);
      chk("midrst_empty", obj_empty, 0);
      send_frame(vt[1]);
      frame_end_check("after_rst", 33, 2, 4, 4, 0);
    end

    // Random pass-through: every output equals the input one cycle earlier.
    for (int i = 0; i < 200; i++) begin
      logic [2:0]  r;
      logic [23:0] px;
      r  = 3'($urandom);
      px = 24'($urandom);
      drive(r[0], r[1], r[2], px);
      chk("pt_de", de_out, r[0]);
      chk("pt_vs", v_sync_out, r[1]);
      chk("pt_hs", h_sync_out, r[2]);
`ifndef CENTROID_CROSSHAIR_EN
      chk("pt_pix", pixel_out, px);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
